// File: rtl/insn_stream_reader.sv
// Instruction-stream reader: pops 1-4 bytes from a show-ahead byte FIFO, assembles them little-endian, tracks next IP.
// Latency: done pulses N+1 cycles after an accepted start when the FIFO never runs dry (N = req_len+1).
// Backpressure: an empty FIFO stalls the read indefinitely; a branch (load_new_ip) aborts it and blocks pops.
module insn_stream_reader #(
  parameter logic [15:0] IP_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  req_len,
  input  logic        sext,
  output logic        busy,
  output logic        done,
  output logic [31:0] data,
  output logic [15:0] ip_out,
  input  logic [15:0] new_ip,
  input  logic        load_new_ip,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty
);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  len_q, len_d;
  logic        sext_q, sext_d;
  logic [31:0] data_q, data_d;
  logic [15:0] ip_q, ip_d;
  logic        done_q, done_d;
  logic        pop;

  // A pop happens only while reading, with a byte present and no branch pending.
  assign pop        = (state_q == S_READ) && !fifo_empty && !load_new_ip;
  assign fifo_rd_en = pop;
  assign busy       = (state_q == S_READ);
  assign done       = done_q;
  assign data       = data_q;
  assign ip_out     = ip_q;

  // Next-state logic: branch overrides everything, then request accept / byte assembly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sext_d  = sext_q;
    data_d  = data_q;
    ip_d    = ip_q;
    done_d  = 1'b0;
    if (load_new_ip) begin
      // Branch: new IP, abandon the read; partially assembled data is left as is.
      ip_d    = new_ip;
      state_d = S_IDLE;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_d   = req_len;
            sext_d  = sext;
            data_d  = 32'h0;
            idx_d   = 2'd0;
            state_d = S_READ;
          end
        end
        S_READ: begin
          if (pop) begin
            data_d[{idx_q, 3'b000} +: 8] = fifo_rd_data;
            idx_d = idx_q + 2'd1;
            ip_d  = ip_q + 16'd1;
            if (idx_q == len_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              // Single-byte fields may be widened signed for displacement-style operands.
              if ((len_q == 2'd0) && sext_q) begin
                data_d[31:8] = {24{fifo_rd_data[7]}};
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      len_q   <= 2'd0;
      sext_q  <= 1'b0;
      data_q  <= 32'h0;
      ip_q    <= IP_RESET;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sext_q  <= sext_d;
      data_q  <= data_d;
      ip_q    <= ip_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_insn_stream_reader.sv
// Bench for insn_stream_reader: byte-FIFO model plus per-scenario tasks.
// Expected data/IP come from the list of bytes offered and simple IP arithmetic.
// The FIFO model changes its outputs just after each rising edge; the bench checks on falling edges.
module tb_insn_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  req_len = 2'd0;
  logic        sext = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] data;
  logic [15:0] ip_out;
  logic [15:0] new_ip = 16'h0;
  logic        load_new_ip = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;

  int total = 0;
  int bad = 0;

  // FIFO model storage: tasks own wr_ptr/flush_ptr, the model process owns rd_ptr/pop_total.
  logic [7:0] mem [0:1023];
  int  wr_ptr = 0;
  int  flush_ptr = 0;
  int  rd_ptr = 0;
  int  pop_total = 0;
  bit  pend = 1'b0;
  bit  gap_en = 1'b0;
  bit  gap_now = 1'b0;

  logic [15:0] exp_ip = 16'h0000;
  logic [31:0] last_data = 32'h0;

  insn_stream_reader #(.IP_RESET(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(start), .req_len(req_len), .sext(sext),
    .busy(busy), .done(done), .data(data), .ip_out(ip_out),
    .new_ip(new_ip), .load_new_ip(load_new_ip),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  // Capture whether the DUT is popping in this cycle, well after inputs settle.
  always @(negedge clk) begin
    #3;
    pend = fifo_rd_en;
  end

  // Apply the pop, flushes and random gaps, then present the new head.
  always @(posedge clk) begin
    #1;
    if (rd_ptr < flush_ptr) rd_ptr = flush_ptr;
    if (pend && (rd_ptr < wr_ptr)) begin
      rd_ptr    = rd_ptr + 1;
      pop_total = pop_total + 1;
    end
    gap_now      = gap_en && ($urandom_range(0, 2) == 0);
    fifo_empty   = (rd_ptr >= wr_ptr) || gap_now;
    fifo_rd_data = (rd_ptr < wr_ptr) ? mem[rd_ptr % 1024] : 8'h00;
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush_fifo();
    flush_ptr = wr_ptr;
  endtask

  // One complete request; caller must be at a falling edge. Returns at the falling edge where done is seen.
  task automatic do_read(input logic [1:0] len, input logic sx, input bit gaps,
                         input logic [31:0] bytes_in, input string name);
    int n;
    int base;
    int it;
    int got;
    bit seen;
    logic [31:0] exp;
    n = int'(len) + 1;
    exp = 32'h0;
    for (int k = 0; k < n; k++) begin
      push_byte(bytes_in[8*k +: 8]);
      exp[8*k +: 8] = bytes_in[8*k +: 8];
    end
    if ((n == 1) && sx && bytes_in[7]) exp[31:8] = 24'hFFFFFF;
    gap_en = gaps;
    base = pop_total;
    seen = 1'b0;
    it = 0;
    start = 1'b1; req_len = len; sext = sx;
    while (!seen && (it < 100)) begin
      @(negedge clk);
      start = 1'b0;
      it++;
      got = pop_total - base;
      total++;
      if (busy !== (got < n)) begin
        bad++; $display("FAIL %s busy it=%0d got=%b want=%b", name, it, busy, (got < n));
      end
      total++;
      if (done !== (got == n)) begin
        bad++; $display("FAIL %s done it=%0d got=%b want=%b", name, it, done, (got == n));
      end
      total++;
      if (fifo_rd_en !== ((got < n) && !fifo_empty)) begin
        bad++; $display("FAIL %s rd_en it=%0d got=%b want=%b", name, it, fifo_rd_en, ((got < n) && !fifo_empty));
      end
      if (got >= n) seen = 1'b1;
    end
    gap_en = 1'b0;
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s timeout got=%0d pops want=%0d", name, pop_total - base, n);
    end
    if (!gaps) begin
      total++;
      if (it != n + 1) begin
        bad++; $display("FAIL %s latency got=%0d want=%0d", name, it, n + 1);
      end
    end
    exp_ip = exp_ip + 16'(n);
    total++;
    if (data !== exp) begin
      bad++; $display("FAIL %s data got=%h want=%h", name, data, exp);
    end
    total++;
    if (ip_out !== exp_ip) begin
      bad++; $display("FAIL %s ip got=%h want=%h", name, ip_out, exp_ip);
    end
    last_data = exp;
  endtask

  task automatic branch(input logic [15:0] tgt);
    load_new_ip = 1'b1; new_ip = tgt;
    @(negedge clk);
    load_new_ip = 1'b0;
    exp_ip = tgt;
    total++;
    if (ip_out !== tgt) begin
      bad++; $display("FAIL branch ip got=%h want=%h", ip_out, tgt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, fifo_rd_en} !== 3'b000) begin
      bad++; $display("FAIL reset flags got=%b want=000", {busy, done, fifo_rd_en});
    end
    total++;
    if (data !== 32'h0) begin
      bad++; $display("FAIL reset data got=%h want=00000000", data);
    end
    total++;
    if (ip_out !== 16'h0000) begin
      bad++; $display("FAIL reset ip got=%h want=0000", ip_out);
    end
    reset = 1'b0;
    exp_ip = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_two_byte();
    do_read(2'd1, 1'b0, 1'b0, 32'h0000_1234, "two_byte");
    total++;
    if (ip_out !== 16'h0002) begin
      bad++; $display("FAIL two_byte ip_abs got=%h want=0002", ip_out);
    end
    @(negedge clk);
  endtask

  task automatic test_sext();
    do_read(2'd0, 1'b1, 1'b0, 32'h0000_0080, "sext_on");
    total++;
    if (data !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL sext_on abs got=%h want=ffffff80", data);
    end
    @(negedge clk);
    do_read(2'd0, 1'b0, 1'b0, 32'h0000_0080, "sext_off");
    @(negedge clk);
  endtask

  task automatic test_gaps();
    do_read(2'd3, 1'b0, 1'b1, 32'hDDCC_BBAA, "gaps");
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL gaps done_width got=%b want=0", done);
    end
  endtask

  task automatic test_wrap();
    branch(16'hFFFF);
    do_read(2'd1, 1'b0, 1'b0, 32'h0000_5A5B, "wrap");
    total++;
    if (ip_out !== 16'h0001) begin
      bad++; $display("FAIL wrap ip_abs got=%h want=0001", ip_out);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int base;
    int it;
    base = pop_total;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    start = 1'b1; req_len = 2'd3; sext = 1'b0;
    it = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      it++;
    end while (((pop_total - base) < 2) && (it < 50));
    total++;
    if ((pop_total - base) != 2) begin
      bad++; $display("FAIL abort pops got=%0d want=2", pop_total - base);
    end
    load_new_ip = 1'b1; new_ip = 16'h1000;
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) begin
      bad++; $display("FAIL abort rd_en got=%b want=0", fifo_rd_en);
    end
    @(negedge clk);
    load_new_ip = 1'b0;
    flush_fifo();
    exp_ip = 16'h1000;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL abort state got=%b want=00", {busy, done});
    end
    total++;
    if (ip_out !== 16'h1000) begin
      bad++; $display("FAIL abort ip got=%h want=1000", ip_out);
    end
    total++;
    if (data !== 32'h0000_2211) begin
      bad++; $display("FAIL abort data_kept got=%h want=00002211", data);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL abort late_done got=%b want=0", done);
    end
    do_read(2'd3, 1'b0, 1'b0, 32'h8877_6655, "after_abort");
    @(negedge clk);
  endtask

  task automatic test_start_during_branch();
    start = 1'b1; load_new_ip = 1'b1; new_ip = 16'h2000; req_len = 2'd0;
    @(negedge clk);
    start = 1'b0; load_new_ip = 1'b0;
    exp_ip = 16'h2000;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL start_drop state got=%b want=00", {busy, done});
    end
    total++;
    if (ip_out !== 16'h2000) begin
      bad++; $display("FAIL start_drop ip got=%h want=2000", ip_out);
    end
  endtask

  task automatic test_back_to_back();
    do_read(2'd1, 1'b0, 1'b0, 32'h0000_BEEF, "b2b_a");
    do_read(2'd2, 1'b0, 1'b0, 32'h00C0_FFEE, "b2b_b");
    do_read(2'd0, 1'b1, 1'b0, 32'h0000_007F, "b2b_c");
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]  len;
    logic        sx;
    bit          gp;
    logic [31:0] b;
    int          idle;
    for (int i = 0; i < 24; i++) begin
      len = 2'($urandom_range(0, 3));
      sx  = 1'($urandom_range(0, 1));
      gp  = ($urandom_range(0, 1) == 1);
      b   = $urandom;
      do_read(len, sx, gp, b, "random");
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00 || data !== last_data) begin
          bad++; $display("FAIL random_hold got=%b/%h want=00/%h", {busy, done}, data, last_data);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int base;
    int it;
    base = pop_total;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    start = 1'b1; req_len = 2'd3; sext = 1'b0;
    it = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      it++;
    end while (((pop_total - base) < 1) && (it < 50));
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, fifo_rd_en} !== 3'b000) begin
      bad++; $display("FAIL reset_mid flags got=%b want=000", {busy, done, fifo_rd_en});
    end
    total++;
    if (data !== 32'h0 || ip_out !== 16'h0000) begin
      bad++; $display("FAIL reset_mid regs got=%h/%h want=00000000/0000", data, ip_out);
    end
    @(negedge clk);
    reset = 1'b0;
    flush_fifo();
    exp_ip = 16'h0000;
    @(negedge clk);
    do_read(2'd1, 1'b0, 1'b0, 32'h0000_9A9B, "after_reset");
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_sext();
    test_gaps();
    test_wrap();
    test_abort();
    test_start_during_branch();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/insn_stream_reader.md
Name: insn_stream_reader

Overview:
Consumer side of the prefetch instruction-stream FIFO. On a request from the decoder/microcode it pops 1-4 bytes from the show-ahead byte FIFO, assembles them little-endian into a 32-bit field with optional sign extension of single bytes, and tracks the IP of the next unconsumed byte. A branch loads a new IP, aborts any read in progress and suppresses pops while the prefetcher flushes the FIFO.

Parameters:
IP_RESET, 16'h0000, value of ip_out after reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
req_len  input  2  bytes to read minus one (0 = 1 byte, 3 = 4 bytes)
sext  input  1  sign-extend result when req_len == 0
busy  output  1  request in progress (state READ)
done  output  1  one-cycle pulse: data valid
data  output  32  assembled field; byte k at data[8k+7:8k]
ip_out  output  16  IP of next byte to be consumed
new_ip  input  16  branch target
load_new_ip  input  1  branch: load IP, abort request
fifo_rd_en  output  1  pop strobe to FIFO
fifo_rd_data  input  8  FIFO head byte, valid whenever !fifo_empty
fifo_empty  input  1  FIFO has no bytes

Behaviour:
- Reset (async): state IDLE, busy 0, done 0, data 0, ip_out IP_RESET, internal byte index 0, latched length 0.
- States: IDLE, READ. busy = (state == READ).
- IDLE, start=1, load_new_ip=0: latch req_len and sext; data <= 0; index <= 0; go to READ. start while in READ is ignored.
- READ: fifo_rd_en = !fifo_empty && !load_new_ip (combinational; 0 in IDLE). Each pop:
  - data[8*index +: 8] <= fifo_rd_data
  - index increments
  - ip_out <= ip_out + 1, wrapping 16'hFFFF -> 16'h0000
- Stall: fifo_empty holds state, index, data and ip_out unchanged. There is no timeout.
- Completion: on the pop with index == latched length, go to IDLE and set done <= 1 for exactly one cycle.
  - If latched length == 0 and sext, data[31:8] <= {24{fifo_rd_data[7]}} on that same pop.
  - Otherwise upper unused bytes stay 0.
- Latency: with the FIFO non-empty, done is high N+1 cycles after the start cycle, where N = req_len+1.
- data holds its value until the next accepted start.
- Back-to-back: start in the done cycle is accepted, since the state is already IDLE.
- load_new_ip has highest priority, in any state:
  - ip_out <= new_ip; state <= IDLE; index <= 0; done <= 0.
  - fifo_rd_en is forced 0 that cycle; any pop that would have happened is discarded.
  - A simultaneous start is dropped.
  - A simultaneous completing pop produces no done.
  - data is not cleared.
- Reset mid-READ: immediate return to reset values, no done.

Test Plan:
- Reset, IP_RESET=16'h0000 -> busy=0, done=0, data=0, ip_out=0000, fifo_rd_en=0.
- FIFO holds 34 12 (head first); start, req_len=1 -> two pops in consecutive cycles; done one cycle later; data=32'h00001234; ip_out=0002.
- FIFO holds 80; start, req_len=0, sext=1 -> data=32'hFFFFFF80. Repeat with sext=0 -> data=32'h00000080.
- req_len=3 with fifo_empty toggling (bytes AA BB CC DD arriving with gaps) -> fifo_rd_en only when !fifo_empty; data=32'hDDCCBBAA; busy stays high across gaps; done single-cycle.
- ip_out=FFFF, 2-byte read -> ip_out=0001 after completion (wrap).
- load_new_ip with new_ip=1000 mid 4-byte read after 2 pops -> same cycle fifo_rd_en=0; next cycle state IDLE, ip_out=1000, no done pulse. Next start reads fresh bytes from index 0.
